// File: rtl/wb_master_xfer.sv
// wb_master_xfer
//   Single-transfer Wishbone B4 pipelined initiator. Takes one command from a
//   valid/ready command port, runs one Wishbone cycle, waits for ack/err/rty
//   or a timeout, then presents data and status on a valid/ready response port.
//
// Ports
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake (ready = FSM idle)
//   cmd_we_i/adr_i/sel_i/dat_i  command contents
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_dat_o                 read data (0 unless a read ended with ack)
//   rsp_status_o              00 ack, 01 err, 10 rty, 11 timeout
//   wb_*                      Wishbone B4 pipelined initiator signals
//   busy_o                    high whenever the FSM is not idle
module wb_master_xfer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
  input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_dat_o,
  output logic [1:0]              rsp_status_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  input  logic                    wb_stall_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic                    busy_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] ST_ACK = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]            rsp_status_q, rsp_status_d;
  logic                  busy_q, busy_d;

  logic timed_out;
  logic term;
  logic [CW-1:0] cnt_inc;

  // Counter value N is seen in the (N+1)-th bus cycle, so the timeout fires
  // N+1 cycles after cyc rises; TIMEOUT=0 never fires.
  assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_VAL);
  assign term      = wb_ack_i | wb_err_i | wb_rty_i;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    dat_d        = dat_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          adr_d   = cmd_adr_i;
          sel_d   = cmd_sel_i;
          dat_d   = cmd_dat_i;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (timed_out) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TMO;
          rsp_dat_d    = '0;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (!wb_stall_i) begin
            stb_d   = 1'b0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (term) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          if (wb_err_i)      rsp_status_d = ST_ERR;
          else if (wb_rty_i) rsp_status_d = ST_RTY;
          else               rsp_status_d = ST_ACK;
          rsp_dat_d = (!we_q && !wb_err_i && !wb_rty_i) ? wb_dat_i : '0;
          state_d   = S_DONE;
        end else if (timed_out) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TMO;
          rsp_dat_d    = '0;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      dat_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_ACK;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      dat_q        <= dat_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
      busy_q       <= busy_d;
    end
  end

  assign cmd_ready_o  = (state_q == S_IDLE);
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = stb_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_sel_o     = sel_q;
  assign wb_dat_o     = dat_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_wb_master_xfer.sv
// Testbench for wb_master_xfer (TIMEOUT=8). Each transfer is described by
// its slave behaviour (stall cycles, response delay, termination bits,
// response back-pressure); the expected per-cycle outputs are derived from
// those numbers, and a small word memory stands in for the register bank.
module tb_wb_master_xfer;

  localparam int TO_N = 8;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;
  logic        busy_o;

  wb_master_xfer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO_N)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];

  bit          chk_en = 1'b0;
  logic        e_cyc = 1'b0, e_stb = 1'b0, e_rv = 1'b0, e_rdy = 1'b1, e_busy = 1'b0;
  logic        e_we = 1'b0;
  logic [31:0] e_adr = '0, e_dat_o = '0, e_rdat = '0;
  logic [3:0]  e_sel = '0;
  logic [1:0]  e_st = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, DUT outputs against the current expectation.
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("cyc", wb_cyc_o, e_cyc);
      chk("stb", wb_stb_o, e_stb);
      chk("rsp_valid", rsp_valid_o, e_rv);
      chk("cmd_ready", cmd_ready_o, e_rdy);
      chk("busy", busy_o, e_busy);
      if (e_cyc) begin
        chk("wb_we", wb_we_o, e_we);
        chk("wb_adr", wb_adr_o, e_adr);
        chk("wb_sel", wb_sel_o, e_sel);
        chk("wb_dat", wb_dat_o, e_dat_o);
      end
      if (e_rv) begin
        chk("rsp_dat", rsp_dat_o, e_rdat);
        chk("rsp_status", rsp_status_o, e_st);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle_exp();
    e_cyc = 1'b0; e_stb = 1'b0; e_rv = 1'b0; e_rdy = 1'b1; e_busy = 1'b0;
  endtask

  // term = {err, rty, ack} presented on the (d+1)-th WAIT cycle; 0 = never.
  task automatic run_xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int s, input int d,
                          input logic [2:0] term, input int r, input int g, input bit spur,
                          output logic [1:0] st, output logic [31:0] rd,
                          output int ncyc, output int nstb, output int rise);
    int tc, lcyc, lstb, last;
    bit to;
    logic [31:0] rdata, m, xst;
    logic [1:0] exp_st;
    logic [2:0] sp;
    tc    = s + d + 2;
    to    = (term == 3'b000) || (tc > TO_N + 1);
    lstb  = (s + 1 < TO_N + 1) ? s + 1 : TO_N + 1;
    lcyc  = to ? TO_N + 1 : tc;
    last  = lcyc + r + 1;
    rdata = mem[adr[5:2]];
    exp_st = to ? 2'd3 : term[2] ? 2'd1 : term[1] ? 2'd2 : 2'd0;
    m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};

    for (int i = 0; i < g; i++) begin
      next_cycle();
      cmd_valid_i = 1'b0;
      cmd_adr_i = $urandom; cmd_dat_i = $urandom;
      wb_stall_i = 1'($urandom); wb_dat_i = $urandom;
      xst = $urandom;
      {wb_err_i, wb_rty_i, wb_ack_i} = spur ? xst[2:0] : 3'b000;
      rsp_ready_i = 1'($urandom);
      set_idle_exp();
      @(negedge clk_i);
    end

    ncyc = 0; nstb = 0; rise = -1; st = '0; rd = '0;
    for (int c = 0; c <= last; c++) begin
      next_cycle();
      cmd_valid_i = 1'b1;
      if (c == 0) begin
        cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_dat_i = dat;
        e_we = we; e_adr = adr; e_sel = sel; e_dat_o = dat;
        e_st = exp_st;
        e_rdat = (!we && exp_st == 2'd0) ? rdata : 32'h0;
      end else begin
        cmd_we_i = 1'($urandom); cmd_adr_i = $urandom;
        cmd_sel_i = 4'($urandom); cmd_dat_i = $urandom;
      end
      wb_stall_i = (c >= 1 && c <= s);
      xst = $urandom;
      sp = xst[2:0];
      if (c == tc)
        {wb_err_i, wb_rty_i, wb_ack_i} = term;
      else if (spur && (c <= s + 1 || c > lcyc))
        {wb_err_i, wb_rty_i, wb_ack_i} = sp;
      else
        {wb_err_i, wb_rty_i, wb_ack_i} = 3'b000;
      wb_dat_i = (c == tc) ? rdata : $urandom;
      if (c >= lcyc + 1 + r)  rsp_ready_i = 1'b1;
      else if (c > lcyc)      rsp_ready_i = 1'b0;
      else                    rsp_ready_i = 1'($urandom);
      e_cyc  = (c >= 1 && c <= lcyc);
      e_stb  = (c >= 1 && c <= lstb);
      e_rv   = (c > lcyc && c <= last);
      e_rdy  = (c == 0);
      e_busy = (c >= 1);
      @(negedge clk_i);
      if (wb_cyc_o) ncyc++;
      if (wb_stb_o) nstb++;
      if (rsp_valid_o && rise < 0) begin
        rise = c; st = rsp_status_o; rd = rsp_dat_o;
      end
    end
    if (we && exp_st == 2'd0) mem[adr[5:2]] = (mem[adr[5:2]] & ~m) | (dat & m);
  endtask

  initial begin
    logic [1:0] st;
    logic [31:0] rd;
    int ncyc, nstb, rise;
    int s, d, r, g;
    logic [2:0] term;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n_i = 1'b0;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_sel_i = '0; cmd_dat_i = '0;
    rsp_ready_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    wb_stall_i = 1'b0; wb_dat_i = '0;

    #12;
    chk("reset_cyc", wb_cyc_o, 1'b0);
    chk("reset_stb", wb_stb_o, 1'b0);
    chk("reset_rsp_valid", rsp_valid_o, 1'b0);
    chk("reset_rsp_dat", rsp_dat_o, 32'h0);
    chk("reset_status", rsp_status_o, 2'b00);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_cmd_ready", cmd_ready_o, 1'b1);
    chk("reset_adr", wb_adr_o, 32'h0);
    next_cycle();
    rst_n_i = 1'b1;
    set_idle_exp();
    chk_en = 1'b1;

    // Write then read back, no stall, ack on first WAIT cycle.
    run_xfer(1'b1, 32'h0, 4'hF, 32'hDEADBEEF, 0, 0, 3'b001, 0, 0, 1'b0, st, rd, ncyc, nstb, rise);
    chk("wr_status", st, 2'b00);
    chk("wr_cyc_len", ncyc, 2);
    chk("wr_stb_len", nstb, 1);
    chk("wr_latency", rise, 3);
    run_xfer(1'b0, 32'h0, 4'hF, 32'h0, 0, 0, 3'b001, 0, 1, 1'b0, st, rd, ncyc, nstb, rise);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_cyc_len", ncyc, 2);

    // Stalled read: strobe held 4 cycles, spurious terminations ignored.
    run_xfer(1'b0, 32'h0, 4'hF, 32'h0, 3, 1, 3'b001, 1, 0, 1'b1, st, rd, ncyc, nstb, rise);
    chk("stall_stb_len", nstb, 4);
    chk("stall_data", rd, 32'hDEADBEEF);

    // err + ack together, then rty alone.
    run_xfer(1'b0, 32'h0, 4'hF, 32'h0, 0, 0, 3'b101, 0, 0, 1'b0, st, rd, ncyc, nstb, rise);
    chk("errack_status", st, 2'b01);
    chk("errack_data", rd, 32'h0);
    run_xfer(1'b0, 32'h0, 4'hF, 32'h0, 0, 2, 3'b010, 0, 0, 1'b0, st, rd, ncyc, nstb, rise);
    chk("rty_status", st, 2'b10);

    // Timeout with a late ack landing in DONE.
    run_xfer(1'b0, 32'h0, 4'hF, 32'h0, 0, 9, 3'b001, 2, 0, 1'b0, st, rd, ncyc, nstb, rise);
    chk("tmo_status", st, 2'b11);
    chk("tmo_cyc_len", ncyc, 9);
    chk("tmo_rise", rise, 10);
    chk("tmo_data", rd, 32'h0);

    // Response held off 5 cycles with a new command waiting.
    run_xfer(1'b0, 32'h0, 4'hF, 32'h0, 0, 0, 3'b001, 5, 0, 1'b1, st, rd, ncyc, nstb, rise);
    chk("bp_data", rd, 32'hDEADBEEF);

    // Asynchronous reset while in WAIT.
    chk_en = 1'b0;
    next_cycle();
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h4;
    wb_stall_i = 1'b0; {wb_err_i, wb_rty_i, wb_ack_i} = 3'b000; rsp_ready_i = 1'b1;
    next_cycle();
    cmd_valid_i = 1'b0;
    next_cycle();
    chk("rst_pre_cyc", wb_cyc_o, 1'b1);
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_async_cyc", wb_cyc_o, 1'b0);
    chk("rst_async_stb", wb_stb_o, 1'b0);
    chk("rst_async_rv", rsp_valid_o, 1'b0);
    chk("rst_async_busy", busy_o, 1'b0);
    next_cycle();
    next_cycle();
    rst_n_i = 1'b1;
    set_idle_exp();
    chk_en = 1'b1;
    run_xfer(1'b0, 32'h0, 4'hF, 32'h0, 1, 0, 3'b001, 0, 0, 1'b0, st, rd, ncyc, nstb, rise);
    chk("post_rst_data", rd, 32'hDEADBEEF);
    chk("post_rst_status", st, 2'b00);

    // Randomized transfers.
    for (int n = 0; n < 250; n++) begin
      s = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 11) : $urandom_range(0, 3);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 3);
      term = ($urandom_range(0, 9) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      r = $urandom_range(0, 3);
      g = $urandom_range(0, 2);
      run_xfer(1'($urandom), $urandom, 4'($urandom), $urandom, s, d, term, r, g,
               1'($urandom), st, rd, ncyc, nstb, rise);
    end

    next_cycle();
    cmd_valid_i = 1'b0;
    set_idle_exp();
    @(negedge clk_i);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
